// File: rtl/lease_cache_nway_lease_engine_pkg.sv
// Shared types and constants for the lease cache lease engine.
// Holds the FSM state encoding, the LFSR seed and taps, and the LFSR step function.
package lease_cache_nway_lease_engine_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_EVAL   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lease_cache_nway_lease_engine_victim_select.sv
// Combinational victim choice for one set: lowest expired way first, otherwise
// either the pseudo-random way or the smallest lease (lowest index wins ties).
module lease_cache_nway_lease_engine_victim_select #(
  parameter int  WAYS     = 4,
  parameter int  BW_LEASE = 16,
  parameter bit  MIN_MODE = 1'b0,
  localparam int BW_WAY   = $clog2(WAYS)
) (
  input  logic [WAYS*BW_LEASE-1:0] lease_vec_i,
  input  logic [BW_WAY-1:0]        rand_i,
  output logic [BW_WAY-1:0]        victim_o,
  output logic [WAYS-1:0]          exp_vec_o
);

  logic [WAYS-1:0]     exp_v;
  logic                exp_found;
  logic [BW_WAY-1:0]   exp_way;
  logic [BW_WAY-1:0]   min_way;
  logic [BW_LEASE-1:0] min_val;

  always_comb begin
    exp_v     = '0;
    exp_found = 1'b0;
    exp_way   = '0;
    min_way   = '0;
    min_val   = lease_vec_i[BW_LEASE-1:0];
    for (int w = 0; w < WAYS; w++) begin
      exp_v[w] = (lease_vec_i[w*BW_LEASE +: BW_LEASE] == '0);
    end
    // Scanning downwards leaves the lowest expired index as the winner.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (exp_v[w]) begin
        exp_found = 1'b1;
        exp_way   = BW_WAY'(w);
      end
    end
    // Strict less-than keeps the lowest index on ties.
    for (int w = 1; w < WAYS; w++) begin
      if (lease_vec_i[w*BW_LEASE +: BW_LEASE] < min_val) begin
        min_val = lease_vec_i[w*BW_LEASE +: BW_LEASE];
        min_way = BW_WAY'(w);
      end
    end
  end

  assign exp_vec_o = exp_v;
  assign victim_o  = exp_found ? exp_way : (MIN_MODE ? min_way : rand_i);

endmodule

// File: rtl/lease_cache_nway_lease_engine.sv
// Per-set lease bookkeeping and replacement-way nomination for an N-way lease cache.
// Handshake: a reference is taken on a rising edge where req_i & ready_o; done_o pulses once when it commits.
module lease_cache_nway_lease_engine
  import lease_cache_nway_lease_engine_pkg::*;
#(
  parameter int          WAYS          = 4,
  parameter int          SETS          = 16,
  parameter int          BW_LEASE      = 16,
  parameter int unsigned DEFAULT_LEASE = 1,
  parameter string       VICTIM_MODE   = "RANDOM",
  localparam int         BW_SET        = $clog2(SETS),
  localparam int         BW_WAY        = $clog2(WAYS)
) (
  input  logic                clock_i,
  input  logic                resetn_i,
  input  logic                req_i,
  input  logic [BW_SET-1:0]   set_i,
  input  logic                hit_i,
  input  logic [BW_WAY-1:0]   hit_way_i,
  input  logic [BW_LEASE-1:0] lease_i,
  input  logic                lease_valid_i,
  input  logic                clear_i,
  output logic                ready_o,
  output logic                done_o,
  output logic [BW_WAY-1:0]   victim_way_o,
  output logic [WAYS-1:0]     expired_vec_o,
  output logic                flag_expired_o,
  output logic                flag_defaulted_o,
  output logic [1:0]          state_o
);

  localparam int                  SET_W     = WAYS * BW_LEASE;
  localparam logic [BW_LEASE-1:0] DEF_LEASE = BW_LEASE'(DEFAULT_LEASE);
  localparam bit                  MIN_MODE  = (VICTIM_MODE == "MIN");

  state_e                       state_q, state_d;
  logic [BW_SET-1:0]            init_idx_q;
  logic [15:0]                  lfsr_q;
  logic                         clear_pend_q;
  logic [BW_SET-1:0]            set_q;
  logic                         hit_q;
  logic [BW_WAY-1:0]            hit_way_q;
  logic [BW_LEASE-1:0]          lease_val_q;
  logic                         lease_vld_q;
  logic [WAYS-1:0]              exp_q;
  logic [BW_WAY-1:0]            victim_q;
  logic [BW_WAY-1:0]            target_q;
  logic [SETS*SET_W-1:0]        lease_q;
  logic                         done_q;
  logic [BW_WAY-1:0]            way_out_q;
  logic [WAYS-1:0]              exp_out_q;
  logic                         flag_exp_q;
  logic                         flag_def_q;

  logic [SET_W-1:0]             set_vec;
  logic [SET_W-1:0]             upd_vec;
  logic [BW_WAY-1:0]            sel_victim;
  logic [WAYS-1:0]              sel_exp;

  lease_cache_nway_lease_engine_victim_select #(
    .WAYS     (WAYS),
    .BW_LEASE (BW_LEASE),
    .MIN_MODE (MIN_MODE)
  ) u_victim_select (
    .lease_vec_i (set_vec),
    .rand_i      (lfsr_q[BW_WAY-1:0]),
    .victim_o    (sel_victim),
    .exp_vec_o   (sel_exp)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (init_idx_q == BW_SET'(SETS - 1)) state_d = ST_IDLE;
      ST_IDLE:   if (clear_i) state_d = ST_INIT;
                 else if (req_i) state_d = ST_EVAL;
      ST_EVAL:   state_d = ST_COMMIT;
      // A clear arriving mid-reference is honoured once the update lands.
      ST_COMMIT: state_d = (clear_pend_q || clear_i) ? ST_INIT : ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  // Target way is renewed; every other way ages by one and saturates at zero.
  always_comb begin
    set_vec = lease_q[int'(set_q)*SET_W +: SET_W];
    upd_vec = set_vec;
    for (int w = 0; w < WAYS; w++) begin
      if (BW_WAY'(w) == target_q) begin
        upd_vec[w*BW_LEASE +: BW_LEASE] = lease_vld_q ? lease_val_q : DEF_LEASE;
      end else if (set_vec[w*BW_LEASE +: BW_LEASE] != '0) begin
        upd_vec[w*BW_LEASE +: BW_LEASE] = set_vec[w*BW_LEASE +: BW_LEASE] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= ST_INIT;
      init_idx_q   <= '0;
      lfsr_q       <= LFSR_SEED;
      clear_pend_q <= 1'b0;
      set_q        <= '0;
      hit_q        <= 1'b0;
      hit_way_q    <= '0;
      lease_val_q  <= '0;
      lease_vld_q  <= 1'b0;
      exp_q        <= '0;
      victim_q     <= '0;
      target_q     <= '0;
      lease_q      <= '0;
      done_q       <= 1'b0;
      way_out_q    <= '0;
      exp_out_q    <= '0;
      flag_exp_q   <= 1'b0;
      flag_def_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_next(lfsr_q);
      done_q     <= 1'b0;
      init_idx_q <= (state_q == ST_INIT) ? init_idx_q + 1'b1 : '0;
      case (state_q)
        ST_INIT: lease_q[int'(init_idx_q)*SET_W +: SET_W] <= '0;
        ST_IDLE: begin
          if (req_i && !clear_i) begin
            set_q       <= set_i;
            hit_q       <= hit_i;
            hit_way_q   <= hit_way_i;
            lease_val_q <= lease_i;
            lease_vld_q <= lease_valid_i;
          end
        end
        ST_EVAL: begin
          exp_q        <= sel_exp;
          victim_q     <= sel_victim;
          target_q     <= hit_q ? hit_way_q : sel_victim;
          clear_pend_q <= clear_pend_q | clear_i;
        end
        ST_COMMIT: begin
          lease_q[int'(set_q)*SET_W +: SET_W] <= upd_vec;
          done_q       <= 1'b1;
          way_out_q    <= target_q;
          exp_out_q    <= exp_q;
          flag_exp_q   <= !hit_q && exp_q[victim_q];
          flag_def_q   <= !lease_vld_q;
          clear_pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ready_o          = (state_q == ST_IDLE);
  assign done_o           = done_q;
  assign victim_way_o     = way_out_q;
  assign expired_vec_o    = exp_out_q;
  assign flag_expired_o   = flag_exp_q;
  assign flag_defaulted_o = flag_def_q;
  assign state_o          = state_q;

endmodule
